sss_generator: RTL

Transmit-side counterpart of the SSS detector. On a start request it takes a cell's N_id_1 and N_id_2 and produces the 127-symbol NR secondary synchronization sequence. The sequence is emitted as BPSK IQ samples on an AXI-stream master. It feeds the SSB resource mapper and the loopback testbenches that drive the receive chain.

---
 rtl/sss_generator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sss_generator.sv
// NR secondary synchronization sequence generator: two 7-bit m-sequence LFSRs,
// pre-advanced by the cyclic shifts m0/m1, streamed as BPSK samples over AXI-stream.
module sss_generator #(
  parameter int OUT_DW    = 32,
  parameter int AMPLITUDE = 2 ** (OUT_DW / 2 - 2)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [8:0]        N_id_1_i,
  input  logic [1:0]        N_id_2_i,
  input  logic              start_i,
  output logic              ready_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              sss_bit_o
);

  localparam int               HALF     = OUT_DW / 2;
  localparam logic [HALF-1:0]  AMP_POS  = HALF'(AMPLITUDE);
  localparam logic [HALF-1:0]  AMP_NEG  = HALF'(0) - AMP_POS;
  localparam logic [6:0]       LFSR_INIT = 7'b0000001;

  typedef enum logic [1:0] {IDLE, ADVANCE, STREAM} state_e;

  state_e     state_q, state_d;
  logic [6:0] x0_q, x0_d;
  logic [6:0] x1_q, x1_d;
  logic [5:0] c0_q, c0_d;
  logic [6:0] c1_q, c1_d;
  logic [6:0] n_q, n_d;

  logic       legal;
  logic [5:0] m0_base, m0;
  logic [6:0] m1;
  logic       handshake;
  logic       cur_bit;

  // Register bit k holds x(i+k); bit 6 receives the newly computed x(i+7).
  function automatic logic [6:0] step_x0(input logic [6:0] x);
    return {x[4] ^ x[0], x[6:1]};
  endfunction

  function automatic logic [6:0] step_x1(input logic [6:0] x);
    return {x[1] ^ x[0], x[6:1]};
  endfunction

  // Shift derivation: q = floor(N_id_1/112) resolved by range compare, no divider.
  always_comb begin
    legal = (N_id_1_i <= 9'd335) && (N_id_2_i <= 2'd2);
    if (N_id_1_i < 9'd112) begin
      m0_base = 6'd0;
      m1      = 7'(N_id_1_i);
    end else if (N_id_1_i < 9'd224) begin
      m0_base = 6'd15;
      m1      = 7'(N_id_1_i - 9'd112);
    end else begin
      m0_base = 6'd30;
      m1      = 7'(N_id_1_i - 9'd224);
    end
    m0 = m0_base + 6'(N_id_2_i) * 6'd5;
  end

  assign m_axis_out_tvalid = (state_q == STREAM);
  assign handshake         = m_axis_out_tvalid && m_axis_out_tready;
  assign cur_bit           = x0_q[0] ^ x1_q[0];
  assign ready_o           = (state_q == IDLE);
  assign sss_bit_o         = m_axis_out_tvalid && cur_bit;
  assign m_axis_out_tlast  = m_axis_out_tvalid && (n_q == 7'd126);
  assign m_axis_out_tdata  = m_axis_out_tvalid ? {HALF'(0), (cur_bit ? AMP_NEG : AMP_POS)}
                                               : '0;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (start_i && legal) begin
          x0_d    = LFSR_INIT;
          x1_d    = LFSR_INIT;
          c0_d    = m0;
          c1_d    = m1;
          n_d     = 7'd0;
          state_d = (m0 == 6'd0 && m1 == 7'd0) ? STREAM : ADVANCE;
        end
      end
      ADVANCE: begin
        if (c0_q != 6'd0) begin
          x0_d = step_x0(x0_q);
          c0_d = c0_q - 6'd1;
        end
        if (c1_q != 7'd0) begin
          x1_d = step_x1(x1_q);
          c1_d = c1_q - 7'd1;
        end
        if (c0_q <= 6'd1 && c1_q <= 7'd1) state_d = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          x0_d = step_x0(x0_q);
          x1_d = step_x1(x1_q);
          n_d  = n_q + 7'd1;
          if (n_q == 7'd126) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      x0_q    <= LFSR_INIT;
      x1_q    <= LFSR_INIT;
      c0_q    <= '0;
      c1_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      n_q     <= n_d;
    end
  end

endmodule
